// File: rtl/sonar_pkg.sv
// Shared sonar definitions: ping state encoding, default sweep limits and the
// timeout range marker used by the sequencer, display and beamformers.
package sonar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        BURST,
        GUARD,
        LISTEN,
        REPORT
    } ping_state_t;

    localparam int DEF_ANGLE_MIN   = -30;
    localparam int DEF_ANGLE_MAX   = 30;
    localparam int DEF_ANGLE_STEP  = 10;
    localparam int DEF_RANGE_WIDTH = 16;

    localparam logic [DEF_RANGE_WIDTH-1:0] TIMEOUT_RANGE = '1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/angle_stepper.sv
// Sweep pointer for the beam angle: sawtooth MIN, MIN+STEP, ..., MAX, MIN, ...
// advancing once per advance_in pulse.
module angle_stepper
    import sonar_pkg::*;
#(
    parameter int ANGLE_WIDTH = 7,
    parameter int ANGLE_MIN   = DEF_ANGLE_MIN,
    parameter int ANGLE_MAX   = DEF_ANGLE_MAX,
    parameter int ANGLE_STEP  = DEF_ANGLE_STEP
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          advance_in,
    output logic signed [ANGLE_WIDTH-1:0] angle_out
);

    localparam logic signed [ANGLE_WIDTH-1:0] MIN_A  = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic signed [ANGLE_WIDTH-1:0] MAX_A  = ANGLE_WIDTH'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH-1:0] STEP_A = ANGLE_WIDTH'(ANGLE_STEP);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            angle_out <= MIN_A;
        end else if (advance_in) begin
            angle_out <= (angle_out == MAX_A) ? MIN_A : angle_out + STEP_A;
        end
    end

endmodule

// File: rtl/ping_sequencer.sv
// One-ping-at-a-time sonar controller: settle, burst, blanking guard, listen,
// then exactly one hit/timeout record per listen window. All outputs registered.
module ping_sequencer
    import sonar_pkg::*;
#(
    parameter int BURST_CYCLES  = 524288,
    parameter int GUARD_CYCLES  = 65536,
    parameter int LISTEN_CYCLES = 16252928,
    parameter int ANGLE_WIDTH   = 7,
    parameter int ANGLE_MIN     = DEF_ANGLE_MIN,
    parameter int ANGLE_MAX     = DEF_ANGLE_MAX,
    parameter int ANGLE_STEP    = DEF_ANGLE_STEP,
    parameter int RANGE_WIDTH   = DEF_RANGE_WIDTH
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic                          sweep_in,
    input  logic signed [ANGLE_WIDTH-1:0] fixed_angle_in,
    input  logic                          tof_valid_in,
    input  logic        [RANGE_WIDTH-1:0] range_in,
    output logic                          chain_rst_out,
    output logic                          burst_start_out,
    output logic                          tx_enable_out,
    output logic                          rx_enable_out,
    output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
    output logic                          result_valid_out,
    output logic                          result_hit_out,
    output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
    output logic        [RANGE_WIDTH-1:0] result_range_out,
    output logic                          busy_out
);

    localparam int MAX_DUR = max3(BURST_CYCLES, GUARD_CYCLES, LISTEN_CYCLES);
    localparam int PHASE_W = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

    localparam logic [PHASE_W-1:0] BURST_LAST  = PHASE_W'(BURST_CYCLES - 1);
    localparam logic [PHASE_W-1:0] GUARD_LAST  = PHASE_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [PHASE_W-1:0] LISTEN_LAST = PHASE_W'(LISTEN_CYCLES - 1);

    localparam logic signed [ANGLE_WIDTH-1:0] MIN_A   = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic        [RANGE_WIDTH-1:0] TIMEOUT = '1;

    ping_state_t                   state;
    logic        [PHASE_W-1:0]     phase;
    logic                          hit_q;
    logic        [RANGE_WIDTH-1:0] range_q;
    logic                          ping_sweep;
    logic signed [ANGLE_WIDTH-1:0] sweep_angle;
    logic                          advance;

    // The pointer moves only after a swept ping has reported.
    assign advance = (state == REPORT) && ping_sweep;

    angle_stepper #(
        .ANGLE_WIDTH (ANGLE_WIDTH),
        .ANGLE_MIN   (ANGLE_MIN),
        .ANGLE_MAX   (ANGLE_MAX),
        .ANGLE_STEP  (ANGLE_STEP)
    ) u_angle_stepper (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .advance_in (advance),
        .angle_out  (sweep_angle)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            phase            <= '0;
            hit_q            <= 1'b0;
            range_q          <= '0;
            ping_sweep       <= 1'b0;
            chain_rst_out    <= 1'b0;
            burst_start_out  <= 1'b0;
            tx_enable_out    <= 1'b0;
            rx_enable_out    <= 1'b0;
            beam_angle_out   <= MIN_A;
            result_valid_out <= 1'b0;
            result_hit_out   <= 1'b0;
            result_angle_out <= '0;
            result_range_out <= TIMEOUT;
            busy_out         <= 1'b0;
        end else begin
            chain_rst_out    <= 1'b0;
            burst_start_out  <= 1'b0;
            result_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (enable_in) begin
                        state         <= SETTLE;
                        chain_rst_out <= 1'b1;
                        busy_out      <= 1'b1;
                    end
                end
                SETTLE: begin
                    beam_angle_out  <= sweep_in ? sweep_angle : fixed_angle_in;
                    ping_sweep      <= sweep_in;
                    hit_q           <= 1'b0;
                    range_q         <= TIMEOUT;
                    phase           <= '0;
                    state           <= BURST;
                    tx_enable_out   <= 1'b1;
                    burst_start_out <= 1'b1;
                end
                BURST: begin
                    if (phase == BURST_LAST) begin
                        phase         <= '0;
                        tx_enable_out <= 1'b0;
                        if (GUARD_CYCLES == 0) begin
                            state         <= LISTEN;
                            rx_enable_out <= 1'b1;
                        end else begin
                            state <= GUARD;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                GUARD: begin
                    if (phase == GUARD_LAST) begin
                        phase         <= '0;
                        state         <= LISTEN;
                        rx_enable_out <= 1'b1;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                LISTEN: begin
                    if (tof_valid_in && !hit_q) begin
                        hit_q   <= 1'b1;
                        range_q <= range_in;
                    end
                    // An echo on the final listen cycle still makes the record.
                    if (phase == LISTEN_LAST) begin
                        phase            <= '0;
                        state            <= REPORT;
                        rx_enable_out    <= 1'b0;
                        result_valid_out <= 1'b1;
                        result_hit_out   <= hit_q | tof_valid_in;
                        result_range_out <= hit_q ? range_q : (tof_valid_in ? range_in : TIMEOUT);
                        result_angle_out <= beam_angle_out;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                REPORT: begin
                    phase <= '0;
                    if (enable_in) begin
                        state         <= SETTLE;
                        chain_rst_out <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    phase    <= '0;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ping_sequencer.sv
// Bench for ping_sequencer: a whole-run timeline is planned from the ping timing
// rules, played into two instances (guard 2 and guard 0) and scored per cycle.
module tb_ping_sequencer;

    localparam int NCYC  = 2048;
    localparam int B     = 4;
    localparam int L     = 10;
    localparam int AMIN  = -30;
    localparam int ASTEP = 10;
    localparam int NANG  = 7;

    typedef struct {
        bit                 hit;
        logic [15:0]        rng;
        logic signed [6:0]  ang;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, enable, sweep, tof;
    logic signed [6:0] fixed_angle;
    logic [15:0] range_v;

    logic a_chain, a_bs, a_tx, a_rx, a_valid, a_hit, a_busy;
    logic signed [6:0] a_beam, a_rang;
    logic [15:0] a_rrng;
    logic b_chain, b_bs, b_tx, b_rx, b_valid, b_hit, b_busy;
    logic signed [6:0] b_beam, b_rang;
    logic [15:0] b_rrng;

    ping_sequencer #(.BURST_CYCLES(B), .GUARD_CYCLES(2), .LISTEN_CYCLES(L)) dut_a (
        .clk_in(clk), .rst_in(rst_a), .enable_in(enable), .sweep_in(sweep),
        .fixed_angle_in(fixed_angle), .tof_valid_in(tof), .range_in(range_v),
        .chain_rst_out(a_chain), .burst_start_out(a_bs), .tx_enable_out(a_tx),
        .rx_enable_out(a_rx), .beam_angle_out(a_beam), .result_valid_out(a_valid),
        .result_hit_out(a_hit), .result_angle_out(a_rang), .result_range_out(a_rrng),
        .busy_out(a_busy));

    ping_sequencer #(.BURST_CYCLES(B), .GUARD_CYCLES(0), .LISTEN_CYCLES(L)) dut_b (
        .clk_in(clk), .rst_in(rst_b), .enable_in(enable), .sweep_in(sweep),
        .fixed_angle_in(fixed_angle), .tof_valid_in(tof), .range_in(range_v),
        .chain_rst_out(b_chain), .burst_start_out(b_bs), .tx_enable_out(b_tx),
        .rx_enable_out(b_rx), .beam_angle_out(b_beam), .result_valid_out(b_valid),
        .result_hit_out(b_hit), .result_angle_out(b_rang), .result_range_out(b_rrng),
        .busy_out(b_busy));

    // Stimulus timeline (inputs driven during cycle c)
    bit rst_a_at[NCYC], rst_b_at[NCYC], en_at[NCYC], sw_at[NCYC], tof_at[NCYC], sel_at[NCYC];
    logic signed [6:0] fa_at[NCYC];
    logic [15:0] rng_at[NCYC];
    // Expected outputs during cycle c
    bit exp_chain[NCYC], exp_bs[NCYC], exp_tx[NCYC], exp_rx[NCYC], exp_busy[NCYC], exp_valid[NCYC];
    bit ang_chk[NCYC], rst_chk[NCYC];
    logic signed [6:0] exp_ang[NCYC];

    res_t exp_q[$];
    int g_cyc, sweep_count, cur_cyc, endc;
    bit started;
    int n_chk, n_fail;
    logic signed [6:0] cur_ang;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    function automatic int plan_ping(input int s, input bit sw, input logic signed [6:0] fa, input bit cont);
        int r;
        r = s + 1 + B + g_cyc + L;
        en_at[s-1] = 1'b1;
        sw_at[s]   = sw;
        fa_at[s]   = fa;
        for (int k = s; k < r; k++) en_at[k] = 1'($urandom_range(0, 1));
        en_at[r] = cont;
        if (sw) begin
            cur_ang = 7'(AMIN + ASTEP * (sweep_count % NANG));
            sweep_count++;
        end else begin
            cur_ang = fa;
        end
        exp_chain[s] = 1'b1;
        exp_bs[s+1]  = 1'b1;
        for (int k = s; k <= r; k++) exp_busy[k] = 1'b1;
        for (int k = s + 1; k <= r; k++) begin
            ang_chk[k] = 1'b1;
            exp_ang[k] = cur_ang;
        end
        for (int k = s + 1; k <= s + B; k++) exp_tx[k] = 1'b1;
        for (int k = s + B + g_cyc + 1; k < r; k++) exp_rx[k] = 1'b1;
        exp_valid[r] = 1'b1;
        return r;
    endfunction

    function automatic void add_echo(input int k, input logic [15:0] v);
        tof_at[k] = 1'b1;
        rng_at[k] = v;
    endfunction

    function automatic void add_rand_echoes(input int s, input int r);
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) add_echo($urandom_range(s + 1, r), 16'($urandom));
        if ($urandom_range(0, 2) == 0) add_echo(r - 1, 16'($urandom));
        if ($urandom_range(0, 2) == 0) add_echo(s + B + g_cyc, 16'($urandom));
    endfunction

    // First echo inside the listen window wins; none means timeout.
    function automatic void commit(input int s, input int r);
        res_t e;
        e.hit = 1'b0;
        e.rng = 16'hFFFF;
        e.ang = cur_ang;
        for (int k = s + 1 + B + g_cyc; k < r; k++) begin
            if (tof_at[k] && !e.hit) begin
                e.hit = 1'b1;
                e.rng = rng_at[k];
            end
        end
        exp_q.push_back(e);
    endfunction

    function automatic void plan_reset(input int c, input int r);
        rst_a_at[c] = 1'b1;
        for (int k = c + 1; k <= r; k++) begin
            exp_chain[k] = 0; exp_bs[k] = 0; exp_tx[k] = 0; exp_rx[k] = 0;
            exp_busy[k] = 0; exp_valid[k] = 0; ang_chk[k] = 0;
            en_at[k] = 0; tof_at[k] = 0;
        end
        rst_chk[c+1] = 1'b1;
        void'(exp_q.pop_back());
        sweep_count = 0;
    endfunction

    task automatic apply(input int c);
        rst_a       = rst_a_at[c];
        rst_b       = rst_b_at[c];
        enable      = en_at[c];
        sweep       = sw_at[c];
        fixed_angle = fa_at[c];
        tof         = tof_at[c];
        range_v     = rng_at[c];
    endtask

    always @(negedge clk) begin : mon
        int c;
        bit s;
        logic o_chain, o_bs, o_tx, o_rx, o_valid, o_hit, o_busy;
        logic signed [6:0] o_beam, o_rang;
        logic [15:0] o_rrng;
        res_t e;
        if (started && cur_cyc >= 1 && cur_cyc <= endc) begin
            c = cur_cyc;
            s = sel_at[c];
            o_chain = s ? b_chain : a_chain;
            o_bs    = s ? b_bs    : a_bs;
            o_tx    = s ? b_tx    : a_tx;
            o_rx    = s ? b_rx    : a_rx;
            o_valid = s ? b_valid : a_valid;
            o_hit   = s ? b_hit   : a_hit;
            o_busy  = s ? b_busy  : a_busy;
            o_beam  = s ? b_beam  : a_beam;
            o_rang  = s ? b_rang  : a_rang;
            o_rrng  = s ? b_rrng  : a_rrng;
            chk("chain_rst", c, 32'(o_chain), 32'(exp_chain[c]));
            chk("burst_start", c, 32'(o_bs), 32'(exp_bs[c]));
            chk("tx_enable", c, 32'(o_tx), 32'(exp_tx[c]));
            chk("rx_enable", c, 32'(o_rx), 32'(exp_rx[c]));
            chk("busy", c, 32'(o_busy), 32'(exp_busy[c]));
            chk("result_valid", c, 32'(o_valid), 32'(exp_valid[c]));
            if (ang_chk[c]) chk("beam_angle", c, o_beam, exp_ang[c]);
            if (rst_chk[c]) begin
                chk("reset_beam_angle", c, o_beam, -32'sd30);
                chk("reset_result_range", c, 32'(o_rrng), 32'h0000FFFF);
                chk("reset_result_hit", c, 32'(o_hit), 32'd0);
                chk("reset_result_angle", c, o_rang, 32'd0);
            end
            if (o_valid === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result cycle %0d: got strobe expected none", c);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_hit", c, 32'(o_hit), 32'(e.hit));
                    chk("result_range", c, 32'(o_rrng), 32'(e.rng));
                    chk("result_angle", c, o_rang, e.ang);
                end
            end
        end
    end

    initial begin
        int s, r, c, t;
        bit cont, prev_cont;
        n_chk = 0; n_fail = 0; started = 0; cur_cyc = 0; endc = 0;
        for (int k = 0; k < NCYC; k++) begin
            sw_at[k] = 1'($urandom); fa_at[k] = 7'($urandom); rng_at[k] = 16'($urandom);
            rst_b_at[k] = 1'b1;
        end
        for (int k = 0; k < 4; k++) rst_a_at[k] = 1'b1;
        rst_chk[2] = 1'b1;
        g_cyc = 2; sweep_count = 0;

        s = 8;     r = plan_ping(s, 0, 7'sd0, 0);  add_echo(s + B + g_cyc + 3, 16'd123); commit(s, r);
        s = r + 4; r = plan_ping(s, 0, 7'sd5, 0);
        add_echo(s + B + 1, 16'd77); add_echo(s + B + g_cyc, 16'd88); add_echo(r, 16'd99); commit(s, r);
        s = r + 3; r = plan_ping(s, 0, -7'sd7, 1);
        add_echo(s + B + g_cyc + 2, 16'd50); add_echo(s + B + g_cyc + 5, 16'd80); commit(s, r);
        for (int i = 0; i < 8; i++) begin
            s = r + 1; r = plan_ping(s, 1, 7'sd0, (i < 7)); add_rand_echoes(s, r); commit(s, r);
        end
        prev_cont = 0;
        for (int i = 0; i < 20; i++) begin
            cont = 1'($urandom);
            s = prev_cont ? r + 1 : r + 2 + $urandom_range(0, 3);
            r = plan_ping(s, 1'($urandom), 7'($urandom), cont);
            add_rand_echoes(s, r); commit(s, r);
            prev_cont = cont;
        end
        s = prev_cont ? r + 1 : r + 2;
        r = plan_ping(s, 1, 7'sd0, 1); add_rand_echoes(s, r); commit(s, r);
        c = s + 1 + B + g_cyc + 5;
        plan_reset(c, r);
        s = c + 3; r = plan_ping(s, 1, 7'sd0, 0); commit(s, r);

        t = r + 3;
        for (int k = t; k < NCYC; k++) rst_a_at[k] = 1'b1;
        for (int k = t + 2; k < NCYC; k++) begin
            rst_b_at[k] = 1'b0; sel_at[k] = 1'b1;
        end
        rst_chk[t+2] = 1'b1;
        g_cyc = 0; sweep_count = 0;
        s = t + 5; r = plan_ping(s, 1, 7'sd0, 1); add_echo(r - 1, 16'd321); commit(s, r);
        for (int i = 0; i < 5; i++) begin
            s = r + 1;
            r = plan_ping(s, (i < 3) ? 1'b1 : 1'($urandom), 7'($urandom), (i < 4));
            add_rand_echoes(s, r); commit(s, r);
        end
        endc = r + 6;

        started = 1;
        apply(0);
        for (int k = 1; k <= endc; k++) begin
            @(posedge clk);
            #1;
            cur_cyc = k;
            apply(k);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_results: got %0d outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
